// File: rtl/mul4_share_arbiter.sv
// Two-requester round-robin front end sharing one 4x4 array multiplier.
// Define MUL4_OPREG_EN to register operands first (CALC state, latency 2).
module mul4_share_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_prod,
    output logic       rsp_id,
    output logic       busy
);

`ifdef MUL4_OPREG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic       r_id;
    logic [7:0] r_prod;
    logic       w_grant;
    logic       w_can;
    logic       w_accept;
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [3:0] w_mul_a;
    logic [3:0] w_mul_b;
    logic [7:0] w_prod;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        w_grant = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end
    end

`ifdef MUL4_OPREG_EN
    logic [3:0] r_a;
    logic [3:0] r_b;
    assign w_can   = !rst && (r_state == IDLE);
    assign w_mul_a = r_a;
    assign w_mul_b = r_b;
`else
    assign w_can   = !rst && ((r_state == IDLE) || ((r_state == HOLD) && rsp_ready));
    assign w_mul_a = w_a;
    assign w_mul_b = w_b;
`endif

    assign req0_ready = w_can && req0_valid && !w_grant;
    assign req1_ready = w_can && req1_valid && w_grant;
    assign w_accept   = req0_ready || req1_ready;
    assign w_a        = w_grant ? req1_a : req0_a;
    assign w_b        = w_grant ? req1_b : req0_b;

    // Array multiplier: each partial-product row is rippled into the running sum.
    always_comb begin
        logic [7:0] acc;
        logic       carry;
        logic       pp;
        logic       sum;
        acc = '0;
        for (int j = 0; j < 4; j++) begin
            acc[j] = w_mul_a[j] & w_mul_b[0];
        end
        for (int i = 1; i < 4; i++) begin
            carry = 1'b0;
            for (int j = 0; j < 4; j++) begin
                pp         = w_mul_a[j] & w_mul_b[i];
                sum        = acc[i+j] ^ pp ^ carry;
                carry      = (acc[i+j] & pp) | (carry & (acc[i+j] ^ pp));
                acc[i+j]   = sum;
            end
            acc[i+4] = carry;
        end
        w_prod = acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef MUL4_OPREG_EN
                    w_next = CALC;
`else
                    w_next = HOLD;
`endif
                end
            end
`ifdef MUL4_OPREG_EN
            CALC: w_next = HOLD;
`endif
            HOLD: begin
                if (rsp_ready) begin
                    w_next = w_accept ? HOLD : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
            r_id   <= 1'b0;
            r_last <= ~RR_INIT;
`ifdef MUL4_OPREG_EN
            r_a    <= '0;
            r_b    <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_last <= w_grant;
                r_id   <= w_grant;
`ifdef MUL4_OPREG_EN
                r_a    <= w_a;
                r_b    <= w_b;
`else
                r_prod <= w_prod;
`endif
            end
`ifdef MUL4_OPREG_EN
            if (r_state == CALC) begin
                r_prod <= w_prod;
            end
`endif
        end
    end

    assign rsp_valid = (r_state == HOLD);
    assign rsp_prod  = r_prod;
    assign rsp_id    = r_id;
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/mul4_share_arbiter.md
MUL4_SHARE_ARBITER -- requirements
Module: mul4_share_arbiter

Interface
REQ-001 SHALL have parameter: RR_INIT, default 0, requester favoured on the first tie after reset (0 or 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has an operand pair.
REQ-005 SHALL have port: req0_ready  output  1  requester 0 pair accepted this cycle when valid also high.
REQ-006 SHALL have port: req0_a, req0_b  input  4 each  requester 0 unsigned operands.
REQ-007 SHALL have ports: req1_valid, req1_ready, req1_a, req1_b, same meanings for requester 1.
REQ-008 SHALL have port: rsp_valid  output  1  result available.
REQ-009 SHALL have port: rsp_ready  input  1  consumer takes the result.
REQ-010 SHALL have port: rsp_prod  output  8  unsigned product a*b.
REQ-011 SHALL have port: rsp_id  output  1  requester that issued the result.
REQ-012 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL share one combinational 4x4 unsigned array multiplier (AND partial products, full-adder ripple array) between both requesters; 8-bit product, no truncation.
REQ-014 SHALL implement states IDLE, CALC (only when MUL4_OPREG_EN is defined) and HOLD.
REQ-015 Grant: only one valid, grant it; both valid, grant the requester other than the last one granted; pointer updates only on an accepted transfer.
REQ-016 reqN_ready SHALL be high only for the granted requester, and only when state is IDLE, or state is HOLD with rsp_ready high; never both readys high.
REQ-017 Accept (valid and ready) without the macro: product, id registered; next state HOLD; rsp_valid high next cycle (latency 1).
REQ-018 HOLD with rsp_ready high: result consumed; with a new accept in the same cycle, stay HOLD with the new result (back-to-back, no bubble); otherwise go to IDLE and drop rsp_valid.
REQ-019 HOLD with rsp_ready low: rsp_valid, rsp_prod and rsp_id SHALL hold stable; no accept.
REQ-020 Requester operands SHALL be sampled only on the accept edge; later changes SHALL not affect the pending result.
REQ-021 rsp_valid SHALL never be high in IDLE or CALC.
REQ-022 busy SHALL be a registered-state decode, never combinationally dependent on inputs.

Reset
REQ-023 With rst high at a clock edge: state IDLE, rsp_valid 0, rsp_prod 0, rsp_id 0, busy 0, grant pointer set so RR_INIT wins the next tie.
REQ-024 Reset mid-operation (CALC or HOLD) SHALL discard the in-flight result; no rsp_valid pulse follows.
REQ-025 While rst is high, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-026 Macro MUL4_OPREG_EN defined: accept registers operands and id, goes to CALC; CALC to HOLD unconditionally next cycle with registered product; latency 2; no accept in CALC, so no back-to-back accept from HOLD (REQ-018 back-to-back path disabled; HOLD with rsp_ready high goes to IDLE).
REQ-027 Macro MUL4_OPREG_EN undefined: no CALC state, no operand register; behaviour per REQ-017/018.

Verification
REQ-028 Reset, then req0 a=15 b=15 valid one cycle, rsp_ready=1 -> rsp_valid next cycle, rsp_prod=225, rsp_id=0; IDLE after.
REQ-029 Both valid same cycle, req0 3x5 and req1 7x9, rsp_ready=1 held -> id0 prod 15 then id1 prod 63 on consecutive cycles; third tie grants requester 0.
REQ-030 Accept req1 6x6, rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_prod=36 stable, both readys 0; rsp_ready=1 -> consumed, IDLE.
REQ-031 rst=1 during HOLD holding 12x12 -> next cycle rsp_valid=0, busy=0, rsp_prod=0; no 144 ever presented.
REQ-032 All 256 pairs on req1 with random rsp_ready stalls -> every rsp_prod equals a*b, rsp_id=1, results in order, none lost or duplicated.
REQ-033 MUL4_OPREG_EN defined: req0 9x11 accepted -> busy 1, CALC one cycle, rsp_valid two cycles after accept, rsp_prod=99.
